elevator_dispatcher: RTL and testbench

Hall-call scheduler that shares two elevator cars between the floor call buttons. It latches hall calls and picks the next unassigned call round-robin. It assigns that call to the nearest idle car and hands the target floor over a valid/ready interface. Sits between the hall-button synchronisers and the per-car elevator FSMs; clears a call when the owning car reports arrival.

---
 rtl/elevator_pkg.sv | 11 +
 rtl/elevator_call_picker.sv | 35 +++
 rtl/elevator_dispatcher.sv | 184 ++++++++++++++++++
 tb/tb_elevator_dispatcher.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the two-car hall-call dispatcher.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS_DEF = 4;
  localparam int unsigned FLOOR_W_DEF    = 2;

  typedef logic [FLOOR_W_DEF-1:0] floor_t;
  typedef enum logic [1:0] {IDLE, SCAN, ISSUE} disp_state_e;
  typedef logic car_id_t;

endpackage

// File: rtl/elevator_call_picker.sv
// Rotating-priority call selector: first requested floor at or above ptr, wrapping;
// saturated (aged) requests, when any exist, mask out the rest.
module elevator_call_picker #(
  parameter int unsigned NUM_FLOORS = 4,
  parameter int unsigned FLOOR_W    = 2
) (
  input  logic [NUM_FLOORS-1:0] req,
  input  logic [NUM_FLOORS-1:0] sat,
  input  logic [FLOOR_W-1:0]    ptr,
  output logic                  found,
  output logic [FLOOR_W-1:0]    sel
);

  logic [NUM_FLOORS-1:0] mask;

  always_comb begin
    int unsigned idx;
    logic [FLOOR_W-1:0] idx_f;
    idx   = 0;
    idx_f = '0;
    found = 1'b0;
    sel   = '0;
    mask  = (|(req & sat)) ? (req & sat) : req;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_FLOORS) idx = idx - NUM_FLOORS;
      idx_f = FLOOR_W'(idx);
      if (!found && mask[idx_f]) begin
        found = 1'b1;
        sel   = idx_f;
      end
    end
  end

endmodule

// File: rtl/elevator_dispatcher.sv
// Two-car hall-call dispatcher: latches calls, picks round-robin, hands to nearest idle car.
// Optional call aging enabled by defining ELEV_DISPATCH_AGING_EN.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int unsigned FLOOR_W    = FLOOR_W_DEF,
  parameter int unsigned AGE_LIMIT  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] hall_req,
  input  logic [FLOOR_W-1:0]    car0_floor,
  input  logic                  car0_idle,
  input  logic                  car0_done,
  output logic [FLOOR_W-1:0]    car0_tgt,
  output logic                  car0_tgt_vld,
  input  logic                  car0_tgt_rdy,
  input  logic [FLOOR_W-1:0]    car1_floor,
  input  logic                  car1_idle,
  input  logic                  car1_done,
  output logic [FLOOR_W-1:0]    car1_tgt,
  output logic                  car1_tgt_vld,
  input  logic                  car1_tgt_rdy,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [NUM_FLOORS-1:0] assigned
);

  disp_state_e           state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, assigned_q, assigned_d, owner_q, owner_d;
  logic [FLOOR_W-1:0]    rr_ptr_q, rr_ptr_d, tgt0_q, tgt0_d, tgt1_q, tgt1_d;
  logic                  tie_q, tie_d, busy0_q, busy0_d, busy1_q, busy1_d;
  car_id_t               sel_car_q, sel_car_d, pick_car;

  logic [NUM_FLOORS-1:0] waiting, sat;
  logic                  elig0, elig1, clr0, clr1, hs, pick_vld;
  logic [FLOOR_W-1:0]    pick_floor, iss_floor;
  logic [FLOOR_W:0]      dist0, dist1;

  assign waiting   = pending_q & ~assigned_q;
  assign elig0     = car0_idle & ~busy0_q;
  assign elig1     = car1_idle & ~busy1_q;
  assign clr0      = car0_done & busy0_q;
  assign clr1      = car1_done & busy1_q;
  assign iss_floor = sel_car_q ? tgt1_q : tgt0_q;
  assign hs        = (state_q == ISSUE) && (sel_car_q ? car1_tgt_rdy : car0_tgt_rdy);

  assign dist0 = (pick_floor >= car0_floor) ? ({1'b0, pick_floor} - {1'b0, car0_floor})
                                            : ({1'b0, car0_floor} - {1'b0, pick_floor});
  assign dist1 = (pick_floor >= car1_floor) ? ({1'b0, pick_floor} - {1'b0, car1_floor})
                                            : ({1'b0, car1_floor} - {1'b0, pick_floor});

  elevator_call_picker #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_picker (
    .req   (waiting),
    .sat   (sat),
    .ptr   (rr_ptr_q),
    .found (pick_vld),
    .sel   (pick_floor)
  );

`ifdef ELEV_DISPATCH_AGING_EN
  localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0] age_q [NUM_FLOORS];
  logic [AGE_W-1:0] age_d [NUM_FLOORS];

  always_comb begin
    for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
      age_d[f] = age_q[f];
      sat[f]   = (age_q[f] == AGE_W'(AGE_LIMIT));
      if (!waiting[f] || (hs && iss_floor == FLOOR_W'(f))) age_d[f] = '0;
      else if (!sat[f]) age_d[f] = age_q[f] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned f = 0; f < NUM_FLOORS; f++) age_q[f] <= '0;
    end else begin
      for (int unsigned f = 0; f < NUM_FLOORS; f++) age_q[f] <= age_d[f];
    end
  end
`else
  // A zero limit would saturate every waiting call at once, which selects exactly as round-robin.
  assign sat = (AGE_LIMIT == 0) ? waiting : '0;
`endif

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | hall_req;
    assigned_d = assigned_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    tgt0_d     = tgt0_q;
    tgt1_d     = tgt1_q;
    tie_d      = tie_q;
    busy0_d    = busy0_q & ~clr0;
    busy1_d    = busy1_q & ~clr1;
    sel_car_d  = sel_car_q;
    pick_car   = 1'b0;

    // Arrival clears the floor even if the button is pressed again in the same cycle.
    for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
      if (assigned_q[f] &&
          ((clr0 && tgt0_q == FLOOR_W'(f) && !owner_q[f]) ||
           (clr1 && tgt1_q == FLOOR_W'(f) &&  owner_q[f]))) begin
        pending_d[f]  = 1'b0;
        assigned_d[f] = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (|waiting && (elig0 || elig1)) state_d = SCAN;
      end
      SCAN: begin
        if (!pick_vld || !(elig0 || elig1)) begin
          state_d = IDLE;
        end else begin
          if (elig0 && elig1) begin
            if (dist0 < dist1)      pick_car = 1'b0;
            else if (dist1 < dist0) pick_car = 1'b1;
            else begin
              pick_car = tie_q;
              tie_d    = ~tie_q;
            end
          end else begin
            pick_car = elig1;
          end
          if (pick_car) tgt1_d = pick_floor;
          else          tgt0_d = pick_floor;
          sel_car_d = pick_car;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          assigned_d[iss_floor] = 1'b1;
          owner_d[iss_floor]    = sel_car_q;
          if (sel_car_q) busy1_d = 1'b1;
          else           busy0_d = 1'b1;
          rr_ptr_d = (iss_floor == FLOOR_W'(NUM_FLOORS - 1)) ? '0 : iss_floor + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      assigned_q <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      tgt0_q     <= '0;
      tgt1_q     <= '0;
      tie_q      <= 1'b0;
      busy0_q    <= 1'b0;
      busy1_q    <= 1'b0;
      sel_car_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      assigned_q <= assigned_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      tgt0_q     <= tgt0_d;
      tgt1_q     <= tgt1_d;
      tie_q      <= tie_d;
      busy0_q    <= busy0_d;
      busy1_q    <= busy1_d;
      sel_car_q  <= sel_car_d;
    end
  end

  assign car0_tgt     = tgt0_q;
  assign car1_tgt     = tgt1_q;
  assign car0_tgt_vld = (state_q == ISSUE) && !sel_car_q;
  assign car1_tgt_vld = (state_q == ISSUE) &&  sel_car_q;
  assign pending      = pending_q;
  assign assigned     = assigned_q;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Scoreboard bench for elevator_dispatcher: expected dispatches queued at stimulus, popped on handshake.
module tb_elevator_dispatcher;

  localparam int unsigned NF = 4;
  localparam int unsigned FW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] hall_req;
  logic [FW-1:0] car0_floor, car1_floor, car0_tgt, car1_tgt;
  logic          car0_idle, car0_done, car0_tgt_vld, car0_tgt_rdy;
  logic          car1_idle, car1_done, car1_tgt_vld, car1_tgt_rdy;
  logic [NF-1:0] pending, assigned;

  always #5 clk = ~clk;

  elevator_dispatcher #(.NUM_FLOORS(NF), .FLOOR_W(FW), .AGE_LIMIT(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .hall_req     (hall_req),
    .car0_floor   (car0_floor),
    .car0_idle    (car0_idle),
    .car0_done    (car0_done),
    .car0_tgt     (car0_tgt),
    .car0_tgt_vld (car0_tgt_vld),
    .car0_tgt_rdy (car0_tgt_rdy),
    .car1_floor   (car1_floor),
    .car1_idle    (car1_idle),
    .car1_done    (car1_done),
    .car1_tgt     (car1_tgt),
    .car1_tgt_vld (car1_tgt_vld),
    .car1_tgt_rdy (car1_tgt_rdy),
    .pending      (pending),
    .assigned     (assigned)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [2:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) if (rst) check("one_vld", car0_tgt_vld & car1_tgt_vld, 0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic call(input logic [NF-1:0] v);
    hall_req = v;
    tick();
    hall_req = '0;
  endtask

  task automatic expect_disp(input logic car, input logic [FW-1:0] f);
    exp_q.push_back({car, f});
  endtask

  task automatic done(input logic car);
    if (car) car1_done = 1'b1;
    else     car0_done = 1'b1;
    tick();
    car0_done = 1'b0;
    car1_done = 1'b0;
  endtask

  task automatic wait_dispatch(input int budget);
    logic [2:0] e;
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if ((car0_tgt_vld && car0_tgt_rdy) || (car1_tgt_vld && car1_tgt_rdy)) begin
        seen = 1;
        if (exp_q.size() == 0) begin
          check("spurious", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("disp_car", car1_tgt_vld, e[2]);
          check("disp_tgt", car1_tgt_vld ? car1_tgt : car0_tgt, e[1:0]);
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) check("disp_timeout", seen, 1);
    tick();
  endtask

  task automatic wait_vld(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (car0_tgt_vld || car1_tgt_vld) seen = 1;
    end
    if (!seen) check("vld_timeout", seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;  hall_req = '0;
    car0_floor = '0; car0_idle = 1'b1; car0_done = 1'b0; car0_tgt_rdy = 1'b1;
    car1_floor = '0; car1_idle = 1'b1; car1_done = 1'b0; car1_tgt_rdy = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_pend", pending, 0);
    check("rst_asg", assigned, 0);
    check("rst_vld", {car0_tgt_vld, car1_tgt_vld}, 0);
    check("rst_tgt", {car0_tgt, car1_tgt}, 0);
    tick();
    rst = 1'b1;
    tick();

    // single call with latency check: car1 at floor 3 is nearer to floor 2
    car1_floor = 2'd3;
    call(4'b0100);
    @(negedge clk);
    check("lat_pend", pending, 4'b0100);
    check("lat_v1", {car0_tgt_vld, car1_tgt_vld}, 2'b00);
    @(negedge clk);
    check("lat_v2", {car0_tgt_vld, car1_tgt_vld}, 2'b00);
    @(negedge clk);
    check("lat_v3", {car0_tgt_vld, car1_tgt_vld}, 2'b01);
    check("lat_tgt", car1_tgt, 2);
    expect_disp(1'b1, 2'd2);
    wait_dispatch(10);
    @(negedge clk);
    check("single_asg", assigned, 4'b0100);
    check("single_pend", pending, 4'b0100);
    done(1'b1);
    @(negedge clk);
    check("single_clr", {pending, assigned}, 0);

    // tie between cars at the same floor alternates
    car1_floor = 2'd0;
    call(4'b0010); expect_disp(1'b0, 2'd1); wait_dispatch(10); done(1'b0);
    call(4'b0010); expect_disp(1'b1, 2'd1); wait_dispatch(10); done(1'b1);
    @(negedge clk);
    check("tie_clr", pending, 0);

    // reset in the middle of an offered target
    car0_tgt_rdy = 1'b0;
    car1_idle = 1'b0;
    call(4'b0001);
    wait_vld(10);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_vld", {car0_tgt_vld, car1_tgt_vld}, 0);
    check("mid_rst_state", {pending, assigned}, 0);
    tick();
    rst = 1'b1;
    car0_tgt_rdy = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_vld", {car0_tgt_vld, car1_tgt_vld}, 0);
    check("post_rst_asg", assigned, 0);

    // round-robin over floors 0,1,3 with only car0 eligible, then wrap
    tick();
    call(4'b1011);
    expect_disp(1'b0, 2'd0); wait_dispatch(10);
    @(negedge clk);
    check("rr_pend", pending, 4'b1011);
    check("rr_asg", assigned, 4'b0001);
    done(1'b0);
    expect_disp(1'b0, 2'd1); wait_dispatch(10); done(1'b0);
    expect_disp(1'b0, 2'd3); wait_dispatch(10); done(1'b0);
    @(negedge clk);
    check("rr_clr", pending, 0);
    call(4'b1100);
    expect_disp(1'b0, 2'd2); wait_dispatch(10); done(1'b0);
    expect_disp(1'b0, 2'd3); wait_dispatch(10); done(1'b0);

    // backpressure: target held, new call only latched
    car0_tgt_rdy = 1'b0;
    call(4'b0010);
    wait_vld(10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_vld", car0_tgt_vld, 1);
      check("bp_tgt", car0_tgt, 1);
      if (i == 0) hall_req = 4'b1000;
      if (i == 1) hall_req = '0;
    end
    check("bp_pend", pending, 4'b1010);
    check("bp_asg", assigned, 0);
    expect_disp(1'b0, 2'd1);
    car0_tgt_rdy = 1'b1;
    wait_dispatch(10);
    @(negedge clk);
    check("bp_asg1", assigned, 4'b0010);
    repeat (3) @(negedge clk);
    check("bp_busy", car0_tgt_vld, 0);
    done(1'b0);
    expect_disp(1'b0, 2'd3); wait_dispatch(10); done(1'b0);
    @(negedge clk);
    check("bp_clr", pending, 0);

`ifdef ELEV_DISPATCH_AGING_EN
    // floor 3 ages out while car0 is busy and overrides the round-robin pick of floor 1
    call(4'b0001); expect_disp(1'b0, 2'd0); wait_dispatch(10);
    call(4'b1000);
    repeat (6) tick();
    hall_req = 4'b0010;
    tick();
    hall_req = '0;
    car0_done = 1'b1;
    tick();
    car0_done = 1'b0;
    expect_disp(1'b0, 2'd3); wait_dispatch(10); done(1'b0);
    expect_disp(1'b0, 2'd1); wait_dispatch(10); done(1'b0);
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
